// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU load/store (fixed priority) vs. read-only LCD engine,
// with a starvation guard for the LCD and an owner-tag pipe that routes read data back.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_rd_en,
    input  logic                  cpu_wr_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  lcd_rd_req,
    input  logic [ADDR_WIDTH-1:0] lcd_addr,
    output logic [DATA_WIDTH-1:0] lcd_rdata,
    output logic                  lcd_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_out
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LCD_PEND = 2'd1,
        LCD_INFL = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LCD = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    tag_t                  tag_q [RD_LATENCY];
    tag_t                  tag_d [RD_LATENCY];
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] lcd_rdata_q, lcd_rdata_d;

    logic cpu_req;
    logic lcd_pend;
    logic force_lcd;
    logic cpu_win;
    logic lcd_win;
    tag_t tag_out;

    // Grant and memory-port muxing; the CPU path adds no register stage.
    always_comb begin
        cpu_req   = cpu_rd_en | cpu_wr_en;
        lcd_pend  = lcd_rd_req && ((state_q == IDLE) || (state_q == LCD_PEND));
        force_lcd = lcd_pend && cpu_req && (wait_cnt_q == WAIT_MAX);
        cpu_win   = cpu_req && !force_lcd;
        lcd_win   = lcd_pend && !cpu_win;

        cpu_stall = force_lcd;
        mem_addr  = lcd_win ? lcd_addr : cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wr_en = cpu_win && cpu_wr_en;
        // A simultaneous read+write from the CPU issues only the write.
        mem_rd_en = lcd_win || (cpu_win && cpu_rd_en && !cpu_wr_en);
    end

    // Read return: the oldest tag lines up with mem_rdata, data is passed through
    // on the pulse and captured so the output holds between pulses.
    always_comb begin
        tag_out     = tag_q[RD_LATENCY-1];
        cpu_rvalid  = tag_out.valid && (tag_out.owner == OWN_CPU);
        lcd_rvalid  = tag_out.valid && (tag_out.owner == OWN_LCD);
        cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        lcd_rdata   = lcd_rvalid ? mem_rdata : lcd_rdata_q;
        cpu_rdata_d = cpu_rdata;
        lcd_rdata_d = lcd_rdata;
        err_d       = err_q | (cpu_rd_en & cpu_wr_en);
        err_out     = err_q;

        tag_d[0] = tag_t'{valid: mem_rd_en, owner: (lcd_win ? OWN_LCD : OWN_CPU)};
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // LCD request tracking and starvation counter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (lcd_win) begin
                    state_d = LCD_INFL;
                end else if (lcd_rd_req) begin
                    state_d = LCD_PEND;
                end
            end
            LCD_PEND: begin
                if (!lcd_rd_req) begin
                    state_d = IDLE;
                end else if (lcd_win) begin
                    state_d = LCD_INFL;
                end
            end
            LCD_INFL: begin
                if (lcd_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (lcd_win || !lcd_pend) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments; the tag pipe is a few flops, so it is
    // reset explicitly to drop reads that were in flight when reset hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            lcd_rdata_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            lcd_rdata_q <= lcd_rdata_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a request-level reference model.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 1;
    localparam int MW = 8;

    logic          clk;
    logic          rst;
    logic          cpu_rd_en, cpu_wr_en;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          lcd_rd_req;
    logic [AW-1:0] lcd_addr;
    logic [DW-1:0] lcd_rdata;
    logic          lcd_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_en, mem_wr_en;
    logic [DW-1:0] mem_rdata;
    logic          err_out;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .lcd_rd_req(lcd_rd_req), .lcd_addr(lcd_addr),
        .lcd_rdata(lcd_rdata), .lcd_rvalid(lcd_rvalid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the port: 64 words, reads return L cycles after mem_rd_en.
    logic [DW-1:0] mem_arr [64];
    logic [DW-1:0] rd_pipe [L];
    assign mem_rdata = rd_pipe[L-1];

    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_addr[7:2]] <= mem_wdata;
        rd_pipe[0] <= mem_rd_en ? mem_arr[mem_addr[7:2]] : $urandom;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the LCD request by age, the shadow memory contents,
    // and a list of expected read returns with the cycle each is due.
    typedef struct {
        int            due;
        bit            is_lcd;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] sh [64];
    int            cyc = 0;
    bit            m_busy;
    int            m_age;
    bit            m_err;
    logic [DW-1:0] m_cpu_last, m_lcd_last;

    task automatic model_step();
        bit            creq, lwait, lcd_go, cpu_go, cpu_rd, ret_cpu, ret_lcd;
        logic [DW-1:0] rdat;
        ret_t          r;
        creq    = cpu_rd_en | cpu_wr_en;
        lwait   = lcd_rd_req && !m_busy;
        lcd_go  = lwait && (!creq || m_age >= MW);
        cpu_go  = creq && !lcd_go;
        cpu_rd  = cpu_go && cpu_rd_en && !cpu_wr_en;
        ret_cpu = 1'b0;
        ret_lcd = 1'b0;
        rdat    = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r       = rq.pop_front();
            ret_lcd = r.is_lcd;
            ret_cpu = !r.is_lcd;
            rdat    = r.data;
        end

        check("cpu_stall", 32'(cpu_stall), 32'(creq && lcd_go));
        check("mem_rd_en", 32'(mem_rd_en), 32'(lcd_go || cpu_rd));
        check("mem_wr_en", 32'(mem_wr_en), 32'(cpu_go && cpu_wr_en));
        check("mem_addr", mem_addr, lcd_go ? lcd_addr : cpu_addr);
        if (cpu_go && cpu_wr_en) check("mem_wdata", mem_wdata, cpu_wdata);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(ret_cpu));
        check("lcd_rvalid", 32'(lcd_rvalid), 32'(ret_lcd));
        check("cpu_rdata", cpu_rdata, ret_cpu ? rdat : m_cpu_last);
        check("lcd_rdata", lcd_rdata, ret_lcd ? rdat : m_lcd_last);
        check("err_out", 32'(err_out), 32'(m_err));

        if (ret_cpu) m_cpu_last = rdat;
        if (ret_lcd) begin
            m_lcd_last = rdat;
            m_busy     = 1'b0;
        end
        if (lcd_go) begin
            rq.push_back('{due: cyc + L, is_lcd: 1'b1, data: sh[lcd_addr[7:2]]});
            m_busy = 1'b1;
            m_age  = 0;
        end else if (lwait) begin
            m_age++;
        end else begin
            m_age = 0;
        end
        if (cpu_rd) rq.push_back('{due: cyc + L, is_lcd: 1'b0, data: sh[cpu_addr[7:2]]});
        if (cpu_go && cpu_wr_en) sh[cpu_addr[7:2]] = cpu_wdata;
        if (cpu_rd_en && cpu_wr_en) m_err = 1'b1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rq.delete();
                m_busy     = 1'b0;
                m_age      = 0;
                m_err      = 1'b0;
                m_cpu_last = '0;
                m_lcd_last = '0;
            end else begin
                model_step();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // CPU reads every cycle (advancing its address only when accepted) while the
    // LCD holds one request: the forced slot must land on the 9th cycle.
    task automatic t3_starve(input string tag);
        int n_acc  = 0;
        int lcd_k  = -1;
        int stalls = 0;
        bit st, rv;
        cpu_rd_en  = 1'b1;
        cpu_addr   = 32'h0;
        lcd_rd_req = 1'b1;
        lcd_addr   = 32'h44;
        for (int k = 0; k < 12; k++) begin
            at_neg();
            if (mem_rd_en && mem_addr == 32'h44) lcd_k = k;
            if (cpu_stall) stalls++;
            if (k == 9) begin
                check({tag, "_cpu_retry_addr"}, mem_addr, 32'h20);
                check({tag, "_lcd_rdata"}, lcd_rdata, 32'hA500_0011);
            end
            st = cpu_stall;
            rv = lcd_rvalid;
            step();
            if (!st) begin
                n_acc++;
                cpu_addr = 32'(n_acc * 4);
            end
            if (rv) lcd_rd_req = 1'b0;
        end
        cpu_rd_en = 1'b0;
        check({tag, "_lcd_issue_cycle"}, 32'(lcd_k), 32'd8);
        check({tag, "_stall_count"}, 32'(stalls), 32'd1);
    endtask

    task automatic random_phase(input int n);
        bit st, rv;
        int lage = 0;
        int r, a;
        for (int c = 0; c < n; c++) begin
            at_neg();
            st = cpu_stall;
            rv = lcd_rvalid;
            step();
            if (!st) begin
                r         = $urandom_range(0, 199);
                cpu_rd_en = (r < 70) || (r == 199);
                cpu_wr_en = (r >= 70 && r < 110) || (r == 199);
                a         = $urandom_range(0, 63);
                cpu_addr  = 32'(a * 4);
                cpu_wdata = $urandom;
            end
            if (!lcd_rd_req || rv) begin
                lcd_rd_req = ($urandom_range(0, 2) == 0);
                a          = $urandom_range(0, 63);
                lcd_addr   = 32'(a * 4);
                lage       = 0;
            end else if (++lage > 40) begin
                check("lcd_timeout", 32'(lage), 32'd40);
                lcd_rd_req = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'hA500_0000 | 32'(i);
            sh[i]      = 32'hA500_0000 | 32'(i);
        end
        for (int i = 0; i < L; i++) rd_pipe[i] = '0;
        rst        = 1'b1;
        cpu_rd_en  = 1'b0;
        cpu_wr_en  = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        lcd_rd_req = 1'b0;
        lcd_addr   = '0;
        fork
            monitor();
        join_none

        // Reset state
        at_neg();
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_lcd_rvalid", 32'(lcd_rvalid), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_lcd_rdata", lcd_rdata, 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // T1: lone CPU read
        step();
        cpu_rd_en = 1'b1;
        cpu_addr  = 32'h10;
        at_neg();
        check("t1_mem_rd_en", 32'(mem_rd_en), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_stall", 32'(cpu_stall), 32'd0);
        step();
        cpu_rd_en = 1'b0;
        at_neg();
        check("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("t1_cpu_rdata", cpu_rdata, 32'hA500_0004);
        check("t1_lcd_rvalid", 32'(lcd_rvalid), 32'd0);

        // T2: lone LCD read
        step();
        lcd_rd_req = 1'b1;
        lcd_addr   = 32'h40;
        at_neg();
        check("t2_mem_rd_en", 32'(mem_rd_en), 32'd1);
        check("t2_mem_addr", mem_addr, 32'h40);
        step();
        at_neg();
        check("t2_lcd_rvalid", 32'(lcd_rvalid), 32'd1);
        check("t2_lcd_rdata", lcd_rdata, 32'hA500_0010);
        step();
        lcd_rd_req = 1'b0;
        at_neg();
        check("t2_lcd_rvalid_off", 32'(lcd_rvalid), 32'd0);

        // T3: starvation guard
        step();
        t3_starve("t3");

        // T4: write then LCD read of the same word, interleaved with a CPU read
        cpu_wr_en  = 1'b1;
        cpu_addr   = 32'h20;
        cpu_wdata  = 32'hDEAD_BEEF;
        lcd_rd_req = 1'b1;
        lcd_addr   = 32'h20;
        at_neg();
        check("t4_wr", {30'd0, mem_wr_en, mem_rd_en}, 32'd2);
        step();
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b1;
        cpu_addr  = 32'h24;
        at_neg();
        check("t4_cpu_rd_addr", mem_addr, 32'h24);
        step();
        cpu_rd_en = 1'b0;
        at_neg();
        check("t4_lcd_issue_addr", mem_addr, 32'h20);
        check("t4_cpu_rdata", cpu_rdata, 32'hA500_0009);
        check("t4_no_lcd_pulse", 32'(lcd_rvalid), 32'd0);
        step();
        at_neg();
        check("t4_lcd_rdata", lcd_rdata, 32'hDEAD_BEEF);
        check("t4_lcd_rvalid", 32'(lcd_rvalid), 32'd1);
        check("t4_no_cpu_pulse", 32'(cpu_rvalid), 32'd0);
        check("t4_cpu_rdata_held", cpu_rdata, 32'hA500_0009);
        step();
        lcd_rd_req = 1'b0;

        // T5: read+write together -> write only, sticky error
        cpu_rd_en = 1'b1;
        cpu_wr_en = 1'b1;
        cpu_addr  = 32'h30;
        cpu_wdata = 32'h1234_5678;
        at_neg();
        check("t5_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd2);
        step();
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        at_neg();
        check("t5_err_set", 32'(err_out), 32'd1);
        repeat (3) step();
        at_neg();
        check("t5_err_sticky", 32'(err_out), 32'd1);
        step();
        rst = 1'b1;
        #1;
        check("t5_err_cleared", 32'(err_out), 32'd0);
        at_neg();
        step();
        rst = 1'b0;

        // T6: reset while an LCD read is in flight
        lcd_rd_req = 1'b1;
        lcd_addr   = 32'h40;
        at_neg();
        check("t6_issue", 32'(mem_rd_en), 32'd1);
        @(posedge clk);
        #1;
        check("t6_pulse_before_rst", 32'(lcd_rvalid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_lcd_rvalid_rst", 32'(lcd_rvalid), 32'd0);
        check("t6_lcd_rdata_rst", lcd_rdata, 32'd0);
        check("t6_cpu_rdata_rst", cpu_rdata, 32'd0);
        lcd_rd_req = 1'b0;
        at_neg();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("t6_no_lcd_pulse", 32'(lcd_rvalid), 32'd0);
        end
        step();
        t3_starve("t6_t3");

        // Randomized traffic against the model
        random_phase(3000);
        cpu_rd_en  = 1'b0;
        cpu_wr_en  = 1'b0;
        lcd_rd_req = 1'b0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
